stone_placer: RTL and testbench
===============================

Name: stone_placer

Overview:
- Downstream consumer of the 8-bit cursor location produced by the board pointer: {row[7:4], col[3:0]} on the 16x16 gomoku board.
- On a "place" button press, checks whether the addressed cell is empty. If it is, commits the current player's stone, alternates turn and counts moves; if not, rejects the press.
- Owns the board state. Exposes a read port for the VGA/display stage.
- Emits a one-cycle move event for the win checker downstream.

Parameters:
- SYNC_STAGES, 2, number of metastability flops on place_btn before edge detection (min 2).
- FIRST_PLAYER, 0, player that moves first after reset (0 = black, 1 = white).

Ports:
- clk  input  1  system clock; all state rising-edge.
- reset  input  1  reset, asynchronous, active-high.
- place_btn  input  1  debounced place key, asynchronous to clk; a press = rising edge.
- loca  input  8  cursor location from pointer; [7:4] row, [3:0] col.
- game_over  input  1  from win checker; while high, all presses are rejected.
- rd_addr  input  8  display read address.
- rd_data  output  2  cell at rd_addr; combinational. 00 empty, 01 black, 10 white (11 never stored).
- cur_player  output  1  player to move next.
- move_valid  output  1  one-cycle pulse when a stone is committed.
- move_loca  output  8  location of the last committed or rejected attempt; held between events.
- move_player  output  1  player of the last committed stone; held.
- move_reject  output  1  one-cycle pulse when a press is refused.
- move_count  output  9  stones on board, 0..256.
- board_full  output  1  high when move_count == 256.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, immediate, any state):
  - all 256 cells = 00; state = IDLE; sync chain cleared.
  - cur_player = FIRST_PLAYER; move_count = 0.
  - move_valid = move_reject = 0; move_loca = 0; move_player = 0; board_full = 0; busy = 0.
  - Reset mid-operation abandons the attempt: no write, no pulse.
- Input sync: place_btn passes SYNC_STAGES flops plus one history flop; press_edge = last sync stage & ~history.
- FSM states: IDLE, LATCH, CHECK.
  - IDLE: if press_edge, sample addr_q <= loca and go to LATCH. Otherwise stay.
  - LATCH: cell_q <= board[addr_q]; go to CHECK.
  - CHECK: decide and register results, then go to IDLE.
    - Accept when cell_q == 00, !game_over and !board_full. Then on this edge:
      - board[addr_q] <= {cur_player, ~cur_player};
      - move_valid = 1; move_player = cur_player;
      - cur_player toggles; move_count increments.
    - Otherwise: move_reject = 1; board, cur_player and move_count unchanged.
    - move_loca <= addr_q in both cases.
- Press edges arriving while busy are dropped, not queued.
- loca changes after its sample edge have no effect on the current attempt.
- Latency, with the raw place_btn rise set up before clk edge k and SYNC_STAGES = 2:
  - loca sampled at edge k+2;
  - move_valid or move_reject high for exactly the one cycle after edge k+4;
  - the written cell is visible on rd_data from edge k+4.
- move_valid and move_reject are mutually exclusive; each is high for exactly one cycle per attempt.
- move_count saturates at 256; board_full = (move_count == 256), registered with the count.
- game_over is sampled in CHECK only.
- rd_addr == addr_q during the write cycle: rd_data shows the old value before the edge and the new value after it.

Test Plan:
- Reset, then press at loca 8'h00: move_valid pulses once at edge k+4; move_player = 0; rd_addr 00 reads 01; cur_player = 1; move_count = 1.
- Second press at loca 8'h00: move_reject pulses; cell still 01; cur_player stays 1; move_count stays 1. Then press at 8'h3A: cell 3A reads 10; cur_player = 0; move_count = 2.
- Hold game_over = 1 and press at empty 8'h55: move_reject pulses, cell 55 stays 00. Release game_over and press again: accepted.
- Fill all 256 cells with alternating players: board_full rises with move_count = 256, and cell parity alternates 01/10 in order of placement. A 257th press is rejected and the count stays 256.
- Two press edges 1 cycle apart, and loca changed at edge k+3: exactly one attempt, at the loca sampled at edge k+2.
- Assert reset at the LATCH cycle: no pulse appears, and all cells, count and player return to reset values immediately, without waiting for a clock.

Source files
------------

// File: rtl/stone_placer_if.sv
// rtl/stone_placer_if.sv - cursor/button inputs, move event outputs and display read port of the stone placer
interface stone_placer_if;
   logic       place_btn;
   logic [7:0] loca;
   logic       game_over;
   logic [7:0] rd_addr;
   logic [1:0] rd_data;
   logic       cur_player;
   logic       move_valid;
   logic [7:0] move_loca;
   logic       move_player;
   logic       move_reject;
   logic [8:0] move_count;
   logic       board_full;
   logic       busy;

   modport master (
      output place_btn, loca, game_over, rd_addr,
      input  rd_data, cur_player, move_valid, move_loca, move_player,
             move_reject, move_count, board_full, busy
   );

   modport slave (
      input  place_btn, loca, game_over, rd_addr,
      output rd_data, cur_player, move_valid, move_loca, move_player,
             move_reject, move_count, board_full, busy
   );
endinterface

// File: rtl/stone_placer.sv
// rtl/stone_placer.sv - owns the 16x16 gomoku board; validates place presses, commits stones, alternates turns
module stone_placer #(
   parameter int SYNC_STAGES  = 2,
   parameter bit FIRST_PLAYER = 1'b0
) (
   input logic           clk,
   input logic           reset,
   stone_placer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LATCH, CHECK} state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic [7:0]             addr_q;
   logic [1:0]             cell_q;
   logic [1:0]             board_q [256];
   logic                   cur_player_q;
   logic                   move_valid_q;
   logic                   move_reject_q;
   logic [7:0]             move_loca_q;
   logic                   move_player_q;
   logic [8:0]             move_count_q;
   logic                   board_full_q;

   logic                   press_edge;
   logic                   accept_d;
   logic [8:0]             move_count_d;

   assign press_edge   = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign accept_d     = (cell_q == 2'b00) && !bus.game_over && !board_full_q;
   assign move_count_d = move_count_q + 9'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         sync_q        <= '0;
         hist_q        <= 1'b0;
         addr_q        <= 8'h00;
         cell_q        <= 2'b00;
         cur_player_q  <= FIRST_PLAYER;
         move_valid_q  <= 1'b0;
         move_reject_q <= 1'b0;
         move_loca_q   <= 8'h00;
         move_player_q <= 1'b0;
         move_count_q  <= 9'd0;
         board_full_q  <= 1'b0;
         for (int i = 0; i < 256; i++) begin
            board_q[i] <= 2'b00;
         end
      end else begin
         sync_q        <= {sync_q[SYNC_STAGES-2:0], bus.place_btn};
         hist_q        <= sync_q[SYNC_STAGES-1];
         move_valid_q  <= 1'b0;
         move_reject_q <= 1'b0;

         case (state_q)
            IDLE: begin
               // Edges seen in LATCH/CHECK fall through here unhandled: presses while busy are dropped.
               if (press_edge) begin
                  addr_q  <= bus.loca;
                  state_q <= LATCH;
               end
            end
            LATCH: begin
               cell_q  <= board_q[addr_q];
               state_q <= CHECK;
            end
            CHECK: begin
               move_loca_q <= addr_q;
               if (accept_d) begin
                  board_q[addr_q] <= {cur_player_q, ~cur_player_q};
                  move_valid_q    <= 1'b1;
                  move_player_q   <= cur_player_q;
                  cur_player_q    <= ~cur_player_q;
                  move_count_q    <= move_count_d;
                  board_full_q    <= (move_count_d == 9'd256);
               end else begin
                  move_reject_q <= 1'b1;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.rd_data     = board_q[bus.rd_addr];
   assign bus.cur_player  = cur_player_q;
   assign bus.move_valid  = move_valid_q;
   assign bus.move_loca   = move_loca_q;
   assign bus.move_player = move_player_q;
   assign bus.move_reject = move_reject_q;
   assign bus.move_count  = move_count_q;
   assign bus.board_full  = board_full_q;
   assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_stone_placer.sv
// tb/tb_stone_placer.sv - randomized self-checking bench for stone_placer against a board-level reference model
`timescale 1ns/1ps
module tb_stone_placer;

   logic clk = 1'b0;
   logic reset = 1'b1;

   stone_placer_if sp ();

   stone_placer #(.SYNC_STAGES(2), .FIRST_PLAYER(1'b0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sp)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model: board contents, side to move, stones placed, last mover.
   logic [1:0] mdl_board [256];
   logic       mdl_player;
   int         mdl_count;
   logic       mdl_last_player;
   logic [7:0] mdl_last_loca;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < 256; i++) mdl_board[i] = 2'b00;
      mdl_player      = 1'b0;
      mdl_count       = 0;
      mdl_last_player = 1'b0;
      mdl_last_loca   = 8'h00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      sp.place_btn = 1'b0;
      sp.game_over = 1'b0;
      repeat (2) @(negedge clk);
      mdl_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_rd(input string tag, input logic [7:0] a);
      sp.rd_addr = a;
      #1;
      check(tag, sp.rd_data, mdl_board[a]);
   endtask

   // One full press: raw rise before edge k, decision registered at edge k+4.
   task automatic press(input logic [7:0] loc, input logic gover);
      bit acc;
      @(negedge clk);
      sp.place_btn = 1'b1;
      sp.loca      = loc;
      sp.game_over = gover;
      repeat (3) @(posedge clk);
      #1;
      check("busy_after_sample", sp.busy, 1'b1);
      sp.loca = 8'($urandom);
      @(posedge clk);
      #1;
      check("no_early_pulse", {sp.move_valid, sp.move_reject}, 2'b00);
      acc = (mdl_board[loc] == 2'b00) && !gover && (mdl_count < 256);
      if (acc) begin
         mdl_board[loc]  = mdl_player ? 2'b10 : 2'b01;
         mdl_last_player = mdl_player;
         mdl_player      = ~mdl_player;
         mdl_count++;
      end
      mdl_last_loca = loc;
      @(posedge clk);
      #1;
      check("move_valid", sp.move_valid, acc);
      check("move_reject", sp.move_reject, !acc);
      check("move_loca", sp.move_loca, mdl_last_loca);
      check("move_player", sp.move_player, mdl_last_player);
      check("cur_player", sp.cur_player, mdl_player);
      check("move_count", sp.move_count, mdl_count);
      check("board_full", sp.board_full, mdl_count == 256);
      check("busy_idle", sp.busy, 1'b0);
      check_rd("rd_cell", loc);
      check_rd("rd_random", 8'($urandom));
      @(posedge clk);
      #1;
      check("pulse_one_cycle", {sp.move_valid, sp.move_reject}, 2'b00);
      @(negedge clk);
      sp.place_btn = 1'b0;
      sp.game_over = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   logic [7:0] order [256];
   int         pulses;
   int         nonzero;

   initial begin
      sp.place_btn = 1'b0;
      sp.loca      = 8'h00;
      sp.game_over = 1'b0;
      sp.rd_addr   = 8'h00;
      mdl_reset();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_count", sp.move_count, 9'd0);
      check("rst_player", sp.cur_player, 1'b0);
      check("rst_pulses", {sp.move_valid, sp.move_reject}, 2'b00);
      check("rst_loca", sp.move_loca, 8'h00);
      check("rst_mplayer", sp.move_player, 1'b0);
      check("rst_full", sp.board_full, 1'b0);
      check("rst_busy", sp.busy, 1'b0);
      check_rd("rst_rd", 8'h7E);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Directed opening sequence
      press(8'h00, 1'b0);
      sp.rd_addr = 8'h00;
      #1;
      check("first_stone_black", sp.rd_data, 2'b01);
      press(8'h00, 1'b0);
      press(8'h3A, 1'b0);
      sp.rd_addr = 8'h3A;
      #1;
      check("second_stone_white", sp.rd_data, 2'b10);
      press(8'h55, 1'b1);
      press(8'h55, 1'b0);

      // Randomized presses over a small cell set so collisions are common
      for (int n = 0; n < 60; n++) begin
         press(8'($urandom) & 8'h33, ($urandom_range(0, 4) == 0));
      end

      // Async reset in the LATCH cycle abandons the attempt and clears state without a clock
      @(negedge clk);
      sp.place_btn = 1'b1;
      sp.loca      = 8'hC4;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      mdl_reset();
      check("arst_busy", sp.busy, 1'b0);
      check("arst_count", sp.move_count, 9'd0);
      check("arst_player", sp.cur_player, 1'b0);
      nonzero = 0;
      for (int a = 0; a < 256; a++) begin
         sp.rd_addr = 8'(a);
         #0.01;
         if (sp.rd_data != 2'b00) nonzero++;
      end
      check("arst_board_clear", nonzero, 0);
      @(negedge clk);
      sp.place_btn = 1'b0;
      reset = 1'b0;
      pulses = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         pulses += sp.move_valid + sp.move_reject;
      end
      check("arst_no_pulse", pulses, 0);

      // Two edges a cycle apart plus loca change after the sample: one attempt at the sampled loca
      @(negedge clk);
      sp.place_btn = 1'b1;
      sp.loca      = 8'h21;
      @(posedge clk);
      @(negedge clk);
      sp.place_btn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      sp.place_btn = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      sp.loca = 8'h92;
      @(posedge clk);
      #1;
      mdl_board[8'h21] = 2'b01;
      mdl_last_player  = 1'b0;
      mdl_player       = 1'b1;
      mdl_count        = 1;
      mdl_last_loca    = 8'h21;
      check("dbl_valid", sp.move_valid, 1'b1);
      check("dbl_loca", sp.move_loca, 8'h21);
      pulses = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         pulses += sp.move_valid + sp.move_reject;
      end
      check("dbl_single_attempt", pulses, 0);
      check("dbl_count", sp.move_count, 9'd1);
      check_rd("dbl_cell_a", 8'h21);
      check_rd("dbl_cell_b", 8'h92);
      @(negedge clk);
      sp.place_btn = 1'b0;
      repeat (3) @(negedge clk);

      // Fill the whole board in shuffled order, then one press too many
      do_reset();
      for (int i = 0; i < 256; i++) order[i] = 8'(i);
      for (int i = 255; i > 0; i--) begin
         int j;
         logic [7:0] t;
         j = $urandom_range(0, i);
         t = order[i];
         order[i] = order[j];
         order[j] = t;
      end
      for (int i = 0; i < 256; i++) begin
         press(order[i], 1'b0);
      end
      check("full_flag", sp.board_full, 1'b1);
      check("full_count", sp.move_count, 9'd256);
      check_rd("full_first_black", order[0]);
      press(8'($urandom), 1'b0);
      check("full_count_sat", sp.move_count, 9'd256);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
